adc_channel_averager: RTL and testbench
=======================================

// Module: adc_channel_averager
// PURPOSE
//  Consumes the modular ADC response stream (valid/channel/data) directly downstream of the ADC system.
//  Keeps one boxcar accumulator per channel and emits one decimated average per 2**LOG2_AVG samples of that channel.
//  The ADC response has no backpressure, so results are buffered in a small FIFO that feeds a valid/ready output.
//  Results lost to a full FIFO are flagged.
// PARAMETERS
//  NUM_CH      9   channels tracked (indices 0..NUM_CH-1); 1..32
//  CH_W        5   channel field width
//  DATA_W      12  sample width
//  LOG2_AVG    4   log2 of window length; 0..8 (0 = pass-through)
//  FIFO_DEPTH  4   result FIFO entries; power of 2, >=2
// PORTS
//  clk_clk      in   1        single clock
//  reset_reset  in   1        synchronous, active-high reset
//  adc_valid    in   1        ADC response sample valid (no ready; always accepted)
//  adc_channel  in   CH_W     channel of sample
//  adc_data     in   DATA_W   unsigned sample
//  avg_valid    out  1        FIFO head valid
//  avg_ready    in   1        downstream accepts head when avg_valid&avg_ready
//  avg_channel  out  CH_W     channel of head result
//  avg_data     out  DATA_W   averaged value of head result
//  ovf_sticky   out  1        set when a completed result was dropped
//  ovf_clear    in   1        clears ovf_sticky
// BEHAVIOUR
//  Reset: all accumulators/counters 0, FIFO empty; avg_valid=0, avg_channel=0, avg_data=0, ovf_sticky=0.
//  Reset mid-window discards partial sums; the next window starts fresh.
//  Per-channel state: acc[DATA_W+LOG2_AVG bits], cnt[LOG2_AVG bits]; no accumulator overflow is possible.
//  adc_valid with adc_channel>=NUM_CH: sample ignored, no state change.
//  adc_valid on channel c with cnt!=2**LOG2_AVG-1: acc+=data, cnt+=1.
//  Last sample (cnt==2**LOG2_AVG-1): result=(acc+data)>>LOG2_AVG (truncate); push {c,result}; acc=0, cnt=0.
//  Latency: result pushed at the edge that samples its last input; visible at head on the next cycle if FIFO was empty.
//  Output: head is stable while avg_valid&!avg_ready; pop on avg_valid&avg_ready.
//  Results leave in completion order, across channels.
//  Push+pop in same cycle: both occur, occupancy unchanged; allowed when full (freed slot takes push) and empty (no bypass; pushed entry appears next cycle).
//  Full without pop: new result dropped, acc/cnt still cleared, ovf_sticky<=1.
//  ovf_clear and a drop in same cycle: set wins.
//  FIFO pointers wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.
//  avg_data/avg_channel show the FIFO head storage; they read 0 after reset until the first push.
// CONFIGURATION
//  ADC_AVG_MINMAX_EN defined: per-channel running min/max tracked over each window.
//   Adds outputs avg_min/avg_max (DATA_W each), stored in the FIFO with the result.
//   Tracker reinitialises on the first sample of each window.
//   Both outputs read 0 after reset.
//  Undefined: ports avg_min/avg_max absent; no min/max storage.
// TESTING
//  1 Assert reset_reset 2 cycles with adc_valid=1 -> avg_valid=0, ovf_sticky=0, avg_data=0 throughout; no push.
//  2 LOG2_AVG=4, 16 samples ch3=0x100, avg_ready=1 -> one result ch=3, data=0x100; avg_valid 1 cycle after 16th sample.
//  3 Interleave ch0 data 0..15 with ch1 data 0xFFF x16 -> ch0 data=0x007 (120>>4); ch1 data=0xFFF; completion order kept.
//  4 avg_ready=0, complete 5 results (depth 4) -> 4 held in order, 5th dropped, ovf_sticky=1.
//    Then ovf_clear=1 -> 0; drain yields the 4 originals.
//  5 ch20 samples (NUM_CH=9) x32 -> no result; state of ch0..8 unchanged.
//    Next: reset after 8 samples of ch2=0xFFF, then 16 of 0x010 -> data=0x010.
//  6 ADC_AVG_MINMAX_EN, ch5 samples 0x010..0x01F -> avg_data=0x017, avg_min=0x010, avg_max=0x01F.

Source files
------------

// File: rtl/adc_channel_averager_if.sv
// ADC response stream in, averaged-result valid/ready stream out, overflow flag.
// ADC_AVG_MINMAX_EN adds the per-window min/max result fields.
interface adc_channel_averager_if #(
  parameter int unsigned CH_W   = 5,
  parameter int unsigned DATA_W = 12
);
  logic              adc_valid;
  logic [CH_W-1:0]   adc_channel;
  logic [DATA_W-1:0] adc_data;
  logic              avg_valid;
  logic              avg_ready;
  logic [CH_W-1:0]   avg_channel;
  logic [DATA_W-1:0] avg_data;
  logic              ovf_sticky;
  logic              ovf_clear;
`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_W-1:0] avg_min;
  logic [DATA_W-1:0] avg_max;

  modport master (
    output adc_valid, adc_channel, adc_data, avg_ready, ovf_clear,
    input  avg_valid, avg_channel, avg_data, ovf_sticky, avg_min, avg_max
  );
  modport slave (
    input  adc_valid, adc_channel, adc_data, avg_ready, ovf_clear,
    output avg_valid, avg_channel, avg_data, ovf_sticky, avg_min, avg_max
  );
`else
  modport master (
    output adc_valid, adc_channel, adc_data, avg_ready, ovf_clear,
    input  avg_valid, avg_channel, avg_data, ovf_sticky
  );
  modport slave (
    input  adc_valid, adc_channel, adc_data, avg_ready, ovf_clear,
    output avg_valid, avg_channel, avg_data, ovf_sticky
  );
`endif
endinterface

// File: rtl/adc_channel_averager.sv
// Per-channel boxcar averager with decimation and a result FIFO on a valid/ready output.
// Define ADC_AVG_MINMAX_EN to also track and report the per-window min/max.
module adc_channel_averager #(
  parameter int unsigned NUM_CH     = 9,
  parameter int unsigned CH_W       = 5,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned LOG2_AVG   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                   clk_clk,
  input logic                   reset_reset,
  adc_channel_averager_if.slave adc_if
);
  localparam int unsigned ACC_W = DATA_W + LOG2_AVG;
  localparam int unsigned CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'((1 << LOG2_AVG) - 1);

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CH_W-1:0]   ch_mem_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic              ovf_q, ovf_d;

  logic              push, do_push, pop, drop, full, empty;
  logic [CH_W-1:0]   push_ch;
  logic [DATA_W-1:0] push_data;
  logic [ACC_W-1:0]  sum;

`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_W-1:0] min_q [NUM_CH];
  logic [DATA_W-1:0] min_d [NUM_CH];
  logic [DATA_W-1:0] max_q [NUM_CH];
  logic [DATA_W-1:0] max_d [NUM_CH];
  logic [DATA_W-1:0] min_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] max_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] push_min, push_max, new_min, new_max;
`endif

  // Out-of-range channels never match any loop index, so they are ignored.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_ch   = '0;
    push_data = '0;
    sum       = '0;
`ifdef ADC_AVG_MINMAX_EN
    min_d    = min_q;
    max_d    = max_q;
    push_min = '0;
    push_max = '0;
    new_min  = '0;
    new_max  = '0;
`endif
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (adc_if.adc_valid && adc_if.adc_channel == CH_W'(c)) begin
        sum = acc_q[c] + ACC_W'(adc_if.adc_data);
`ifdef ADC_AVG_MINMAX_EN
        // First sample of a window reinitialises the tracker.
        new_min = (cnt_q[c] == '0 || adc_if.adc_data < min_q[c]) ? adc_if.adc_data : min_q[c];
        new_max = (cnt_q[c] == '0 || adc_if.adc_data > max_q[c]) ? adc_if.adc_data : max_q[c];
        min_d[c] = new_min;
        max_d[c] = new_max;
`endif
        if (cnt_q[c] == LastCnt) begin
          push      = 1'b1;
          push_ch   = adc_if.adc_channel;
          push_data = DATA_W'(sum >> LOG2_AVG);
          acc_d[c]  = '0;
          cnt_d[c]  = '0;
`ifdef ADC_AVG_MINMAX_EN
          push_min = new_min;
          push_max = new_max;
`endif
        end else begin
          acc_d[c] = sum;
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop     = !empty && adc_if.avg_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign ovf_d   = drop ? 1'b1 : (adc_if.ovf_clear ? 1'b0 : ovf_q);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      acc_q      <= '{default: '0};
      cnt_q      <= '{default: '0};
      ch_mem_q   <= '{default: '0};
      data_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
`ifdef ADC_AVG_MINMAX_EN
      min_q     <= '{default: '0};
      max_q     <= '{default: '0};
      min_mem_q <= '{default: '0};
      max_mem_q <= '{default: '0};
`endif
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
`ifdef ADC_AVG_MINMAX_EN
      min_q <= min_d;
      max_q <= max_d;
`endif
      if (do_push) begin
        ch_mem_q[wr_ptr_q[PTR_W-1:0]]   <= push_ch;
        data_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
`ifdef ADC_AVG_MINMAX_EN
        min_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_min;
        max_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_max;
`endif
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign adc_if.avg_valid   = !empty;
  assign adc_if.avg_channel = ch_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign adc_if.avg_data    = data_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign adc_if.ovf_sticky  = ovf_q;
`ifdef ADC_AVG_MINMAX_EN
  assign adc_if.avg_min = min_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign adc_if.avg_max = max_mem_q[rd_ptr_q[PTR_W-1:0]];
`endif
endmodule

// File: tb/tb_adc_channel_averager.sv
// Bench for adc_channel_averager: directed scenarios plus randomized traffic against a queue model.
// Honours ADC_AVG_MINMAX_EN when the design is built with it.
module tb_adc_channel_averager;
  localparam int NUM_CH = 9, CH_W = 5, DATA_W = 12, LOG2_AVG = 4, FIFO_DEPTH = 4;
  localparam int WIN = 1 << LOG2_AVG;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adc_channel_averager_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus ();

  adc_channel_averager #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .LOG2_AVG(LOG2_AVG), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .adc_if(bus)
  );

  typedef struct {int ch; int data; int mn; int mx;} res_t;
  res_t exp_q[$];
  int   win_q[NUM_CH][$];
  bit   exp_ovf;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: collect each channel's samples; a full window yields mean, min and max.
  task automatic cycle(input bit v, input int ch, input int d, input bit rdy, input bit clr,
                       input bit rs);
    res_t r;
    bit   done = 1'b0;
    bus.adc_valid   = v;
    bus.adc_channel = ch[CH_W-1:0];
    bus.adc_data    = d[DATA_W-1:0];
    bus.avg_ready   = rdy;
    bus.ovf_clear   = clr;
    rst             = rs;
    if (rs) begin
      exp_q.delete();
      for (int i = 0; i < NUM_CH; i++) win_q[i].delete();
      exp_ovf = 1'b0;
    end else begin
      if (v && ch < NUM_CH) begin
        win_q[ch].push_back(d);
        if (win_q[ch].size() == WIN) begin
          int s = 0;
          r.mn = win_q[ch][0];
          r.mx = win_q[ch][0];
          for (int i = 0; i < WIN; i++) begin
            s += win_q[ch][i];
            if (win_q[ch][i] < r.mn) r.mn = win_q[ch][i];
            if (win_q[ch][i] > r.mx) r.mx = win_q[ch][i];
          end
          r.ch   = ch;
          r.data = s / WIN;
          win_q[ch].delete();
          done = 1'b1;
        end
      end
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (clr) exp_ovf = 1'b0;
      if (done) begin
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(r);
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 3, $urandom_range(0, 4095), 1'b1, 1'b0, 1'b1);
      n_tests++;
      if (bus.avg_valid !== 1'b0 || bus.ovf_sticky !== 1'b0 || bus.avg_data !== 12'h000 ||
          bus.avg_channel !== 5'd0) begin
        n_fail++;
        $display("FAIL reset: valid=%b ovf=%b data=%h ch=%0d, required 0 0 000 0", bus.avg_valid,
                 bus.ovf_sticky, bus.avg_data, bus.avg_channel);
      end
`ifdef ADC_AVG_MINMAX_EN
      n_tests++;
      if (bus.avg_min !== 12'h000 || bus.avg_max !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_minmax: min=%h max=%h, required 000 000", bus.avg_min, bus.avg_max);
      end
`endif
    end
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_push: avg_valid=%b, required 0", bus.avg_valid);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < WIN; i++) begin
      cycle(1'b1, 3, 'h100, 1'b1, 1'b0, 1'b0);
      if (i == WIN - 2) begin
        n_tests++;
        if (bus.avg_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early: avg_valid=%b after 15 samples, required 0", bus.avg_valid);
        end
      end
    end
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_channel !== 5'd3 || bus.avg_data !== 12'h100) begin
      n_fail++;
      $display("FAIL single: valid=%b ch=%0d data=%h, required 1 3 100", bus.avg_valid,
               bus.avg_channel, bus.avg_data);
    end
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: avg_valid=%b, required 0", bus.avg_valid);
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < WIN; i++) begin
      cycle(1'b1, 0, i, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1, 'hFFF, 1'b0, 1'b0, 1'b0);
    end
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_channel !== 5'd0 || bus.avg_data !== 12'h007) begin
      n_fail++;
      $display("FAIL interleave_first: valid=%b ch=%0d data=%h, required 1 0 007", bus.avg_valid,
               bus.avg_channel, bus.avg_data);
    end
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_channel !== 5'd1 || bus.avg_data !== 12'hFFF) begin
      n_fail++;
      $display("FAIL interleave_second: valid=%b ch=%0d data=%h, required 1 1 FFF", bus.avg_valid,
               bus.avg_channel, bus.avg_data);
    end
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < WIN; i++) cycle(1'b1, k, 'h100 + k, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (bus.ovf_sticky !== 1'b1 || bus.avg_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: ovf=%b valid=%b, required 1 1", bus.ovf_sticky, bus.avg_valid);
    end
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (bus.ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: ovf=%b, required 0", bus.ovf_sticky);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (bus.avg_valid !== 1'b1 || bus.avg_channel !== k[CH_W-1:0] ||
          bus.avg_data !== 12'(32'h100 + k)) begin
        n_fail++;
        $display("FAIL overflow_drain%0d: valid=%b ch=%0d data=%h, required 1 %0d %h", k,
                 bus.avg_valid, bus.avg_channel, bus.avg_data, k, 32'h100 + k);
      end
      cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    end
    n_tests++;
    if (bus.avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_empty: avg_valid=%b, required 0", bus.avg_valid);
    end
  endtask

  task automatic test_illegal_channel();
    int s = 0;
    int d;
    for (int i = 0; i < WIN / 2; i++) begin
      d = $urandom_range(0, 4095);
      s += d;
      cycle(1'b1, 0, d, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2 * WIN; i++) cycle(1'b1, 20, $urandom_range(0, 4095), 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_channel: avg_valid=%b, required 0", bus.avg_valid);
    end
    for (int i = 0; i < WIN / 2; i++) begin
      d = $urandom_range(0, 4095);
      s += d;
      cycle(1'b1, 0, d, 1'b0, 1'b0, 1'b0);
    end
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_channel !== 5'd0 || bus.avg_data !== 12'(s / WIN)) begin
      n_fail++;
      $display("FAIL illegal_keep: valid=%b ch=%0d data=%h, required 1 0 %h", bus.avg_valid,
               bus.avg_channel, bus.avg_data, s / WIN);
    end
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midwindow();
    for (int i = 0; i < WIN / 2; i++) cycle(1'b1, 2, 'hFFF, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < WIN; i++) cycle(1'b1, 2, 'h010, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_channel !== 5'd2 || bus.avg_data !== 12'h010) begin
      n_fail++;
      $display("FAIL reset_midwindow: valid=%b ch=%0d data=%h, required 1 2 010", bus.avg_valid,
               bus.avg_channel, bus.avg_data);
    end
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

`ifdef ADC_AVG_MINMAX_EN
  task automatic test_minmax();
    for (int i = 0; i < WIN; i++) cycle(1'b1, 5, 'h010 + i, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_data !== 12'h017 || bus.avg_min !== 12'h010 ||
        bus.avg_max !== 12'h01F) begin
      n_fail++;
      $display("FAIL minmax: valid=%b data=%h min=%h max=%h, required 1 017 010 01F",
               bus.avg_valid, bus.avg_data, bus.avg_min, bus.avg_max);
    end
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask
`endif

  // Random traffic with phases of scarce ready to exercise full FIFO and push+pop when full.
  task automatic test_back_to_back();
    int chs[5] = '{0, 1, 2, 8, 20};
    int mism = 0;
    for (int n = 0; n < 4000; n++) begin
      bit rdy = ((n / 300) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 3) != 0, chs[$urandom_range(0, 4)], $urandom_range(0, 4095), rdy,
            $urandom_range(0, 63) == 0, $urandom_range(0, 999) == 0);
      n_tests++;
      if (bus.avg_valid !== (exp_q.size() > 0) || bus.ovf_sticky !== exp_ovf) begin
        n_fail++;
        if (mism++ < 10)
          $display("FAIL random_flags@%0d: valid=%b ovf=%b, required %b %b", n, bus.avg_valid,
                   bus.ovf_sticky, exp_q.size() > 0, exp_ovf);
      end
      if (exp_q.size() > 0) begin
        n_tests++;
        if (bus.avg_channel !== exp_q[0].ch[CH_W-1:0] ||
            bus.avg_data !== exp_q[0].data[DATA_W-1:0]
`ifdef ADC_AVG_MINMAX_EN
            || bus.avg_min !== exp_q[0].mn[DATA_W-1:0] || bus.avg_max !== exp_q[0].mx[DATA_W-1:0]
`endif
            ) begin
          n_fail++;
          if (mism++ < 10)
            $display("FAIL random_head@%0d: ch=%0d data=%h, required %0d %h", n, bus.avg_channel,
                     bus.avg_data, exp_q[0].ch, exp_q[0].data);
        end
      end
    end
  endtask

  initial begin
    bus.adc_valid   = 1'b0;
    bus.adc_channel = '0;
    bus.adc_data    = '0;
    bus.avg_ready   = 1'b0;
    bus.ovf_clear   = 1'b0;
    test_reset();
    test_single();
    test_interleave();
    test_overflow();
    test_illegal_channel();
    test_reset_midwindow();
`ifdef ADC_AVG_MINMAX_EN
    test_minmax();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
